// File: rtl/alu_pipe_if.sv
// alu_pipe_if: handshake bundle for alu_pipe.
// The input side carries operand/opcode transactions (in_valid/in_ready) and
// the synchronous accumulator clear; the output side carries the registered
// result, status and flags (out_valid/out_ready).
// master = producer/consumer side, slave = the ALU itself.
// WIDTH must match the WIDTH of the alu_pipe instance bound to it.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       opcode;
    logic             acc_sel;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             status;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, A, B, opcode, acc_sel, acc_clr, out_ready,
        input  in_ready, out_valid, result, status, carry, ovf, zero, neg
    );

    modport slave (
        input  in_valid, A, B, opcode, acc_sel, acc_clr, out_ready,
        output in_ready, out_valid, result, status, carry, ovf, zero, neg
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered one-hot-opcode ALU (add/sub/OR/AND) with an optional
// accumulator first operand, valid/ready on both sides and one cycle latency.
// The result register holds under backpressure; in_ready depends only on
// registered state and out_ready.
// Optional feature: define ALU_PIPE_SAT_EN for unsigned saturation of add/sub
// (carry/ovf still report the raw condition). Undefined: add/sub wrap.
// WIDTH legal range 2..32; it must match the WIDTH of the bound interface.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_pipe_if.slave   bus
);
    // opcode encodings (one-hot)
    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0001;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_status;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;
    logic [WIDTH-1:0] r_acc;

    logic             w_accept;
    logic [WIDTH-1:0] w_acc_eff;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_res;
    logic             w_legal;
    logic             w_carry;
    logic             w_ovf;
    logic             w_is_add;
    logic             w_is_sub;

    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // acc_clr takes effect on the operand in the same cycle it is asserted
    assign w_acc_eff = bus.acc_clr ? '0 : r_acc;
    assign w_op_a    = bus.acc_sel ? w_acc_eff : bus.A;

    // one extra bit: carry-out for add, borrow for sub
    assign w_sum  = {1'b0, w_op_a} + {1'b0, bus.B};
    assign w_diff = {1'b0, w_op_a} - {1'b0, bus.B};

    // decode opcode and form the raw result and arithmetic flags
    always_comb begin
        w_legal  = 1'b1;
        w_is_add = 1'b0;
        w_is_sub = 1'b0;
        w_raw    = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                w_is_add = 1'b1;
                w_raw    = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
                w_ovf    = (w_op_a[WIDTH-1] == bus.B[WIDTH-1]) &&
                           (w_raw[WIDTH-1] != w_op_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_is_sub = 1'b1;
                w_raw    = w_diff[WIDTH-1:0];
                w_carry  = w_diff[WIDTH];
                w_ovf    = (w_op_a[WIDTH-1] != bus.B[WIDTH-1]) &&
                           (w_raw[WIDTH-1] != w_op_a[WIDTH-1]);
            end
            OP_OR:  w_raw = w_op_a | bus.B;
            OP_AND: w_raw = w_op_a & bus.B;
            default: w_legal = 1'b0;
        endcase
    end

    // final result: optional unsigned clamp on carry/borrow
    always_comb begin
        w_res = w_raw;
`ifdef ALU_PIPE_SAT_EN
        if (w_is_add && w_carry) begin
            w_res = '1;
        end else if (w_is_sub && w_carry) begin
            w_res = '0;
        end
`else
        if (w_is_add || w_is_sub) begin
            w_res = w_raw;
        end
`endif
    end

    // output register: load on accept, drop valid when drained with no new accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_status    <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_status    <= w_legal;
            r_carry     <= w_carry;
            r_ovf       <= w_ovf;
            r_zero      <= (w_res == '0);
            r_neg       <= w_res[WIDTH-1];
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // accumulator: legal accepted op wins, else synchronous clear, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept && w_legal) begin
            r_acc <= w_res;
        end else if (bus.acc_clr) begin
            r_acc <= '0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.status    = r_status;
    assign bus.carry     = r_carry;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table-driven vectors plus a few hand sequences for alu_pipe
// (WIDTH = 8). Expected outputs are queued when a transaction is accepted and
// compared when the DUT presents and hands off a result.
// Follows ALU_PIPE_SAT_EN if it is defined for the build.
module tb_alu_pipe;
    localparam int W = 8;
`ifdef ALU_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic       sel;
        logic       clr;
        logic [7:0] r;
        logic       st;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
    } vec_t;

    typedef logic [12:0] out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_pipe_if #(.WIDTH(W)) bus ();
    alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    out_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         txn = 0;
    logic [7:0] m_acc = 8'h00;
    vec_t       tbl[17];

    function automatic vec_t mk(logic [7:0] a, logic [7:0] b, logic [3:0] op,
                                logic sel, logic clr, logic [7:0] r, logic st,
                                logic c, logic v, logic z, logic n);
        vec_t t;
        t.a = a; t.b = b; t.op = op; t.sel = sel; t.clr = clr;
        t.r = r; t.st = st; t.c = c; t.v = v; t.z = z; t.n = n;
        return t;
    endfunction

    // reference model in integer arithmetic, using the tracked accumulator
    function automatic vec_t model(logic [7:0] a, logic [7:0] b, logic [3:0] op,
                                   logic sel, logic clr);
        vec_t t;
        int ua, ub, sa, sb, s;
        t = mk(a, b, op, sel, clr, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ua = sel ? (clr ? 0 : int'(m_acc)) : int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        case (op)
            4'h8: begin
                s = ua + ub;
                t.r = s[7:0];
                t.c = (s > 255);
                t.v = ((sa + sb) > 127) || ((sa + sb) < -128);
                if (SAT && t.c) t.r = 8'hFF;
            end
            4'h4: begin
                s = ua - ub;
                t.r = s[7:0];
                t.c = (ua < ub);
                t.v = ((sa - sb) > 127) || ((sa - sb) < -128);
                if (SAT && t.c) t.r = 8'h00;
            end
            4'h2: begin s = ua | ub; t.r = s[7:0]; end
            4'h1: begin s = ua & ub; t.r = s[7:0]; end
            default: t.st = 1'b0;
        endcase
        t.z = (t.r == 8'h00);
        t.n = t.r[7];
        return t;
    endfunction

    function automatic out_t pack_out(vec_t v);
        return {v.r, v.st, v.c, v.v, v.z, v.n};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.acc_sel  = 1'b0;
        bus.acc_clr  = 1'b0;
    endtask

    // offer one transaction, wait (bounded) for acceptance, queue its expectation
    task automatic send(vec_t v);
        int  k;
        bit  ok;
        k  = 0;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.A        = v.a;
        bus.B        = v.b;
        bus.opcode   = v.op;
        bus.acc_sel  = v.sel;
        bus.acc_clr  = v.clr;
        while (!ok && k < 50) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            else k++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles want 1");
        end else begin
            exp_q.push_back(pack_out(v));
            if (v.st) m_acc = v.r;
            else if (v.clr) m_acc = 8'h00;
            $display("drive a=%h b=%h op=%b sel=%b clr=%b exp r=%h st=%b c=%b v=%b z=%b n=%b",
                     v.a, v.b, v.op, v.sel, v.clr, v.r, v.st, v.c, v.v, v.z, v.n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_check(string name);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [3:0] ops[6];
        ops[0] = 4'h8; ops[1] = 4'h4; ops[2] = 4'h2;
        ops[3] = 4'h1; ops[4] = 4'h0; ops[5] = 4'hC;

        //           a      b      op    sel   clr   r                   st    c     v     z                  n
        tbl[0]  = mk(8'hF0, 8'h20, 4'h8, 1'b0, 1'b0, SAT ? 8'hFF : 8'h10, 1'b1, 1'b1, 1'b0, 1'b0,             SAT);
        tbl[1]  = mk(8'h7F, 8'h01, 4'h8, 1'b0, 1'b0, 8'h80,               1'b1, 1'b0, 1'b1, 1'b0,             1'b1);
        tbl[2]  = mk(8'h05, 8'h05, 4'h4, 1'b0, 1'b0, 8'h00,               1'b1, 1'b0, 1'b0, 1'b1,             1'b0);
        tbl[3]  = mk(8'hAA, 8'h55, 4'h6, 1'b0, 1'b0, 8'h00,               1'b0, 1'b0, 1'b0, 1'b1,             1'b0);
        tbl[4]  = mk(8'h03, 8'h04, 4'h8, 1'b0, 1'b0, 8'h07,               1'b1, 1'b0, 1'b0, 1'b0,             1'b0);
        tbl[5]  = mk(8'hEE, 8'h10, 4'h8, 1'b1, 1'b0, 8'h17,               1'b1, 1'b0, 1'b0, 1'b0,             1'b0);
        tbl[6]  = mk(8'hEE, 8'hFF, 4'h1, 1'b1, 1'b1, 8'h00,               1'b1, 1'b0, 1'b0, 1'b1,             1'b0);
        tbl[7]  = mk(8'h03, 8'h05, 4'h4, 1'b0, 1'b0, SAT ? 8'h00 : 8'hFE, 1'b1, 1'b1, 1'b0, SAT,              !SAT);
        tbl[8]  = mk(8'h80, 8'h01, 4'h4, 1'b0, 1'b0, 8'h7F,               1'b1, 1'b0, 1'b1, 1'b0,             1'b0);
        tbl[9]  = mk(8'hA0, 8'h05, 4'h2, 1'b0, 1'b0, 8'hA5,               1'b1, 1'b0, 1'b0, 1'b0,             1'b1);
        tbl[10] = mk(8'h12, 8'h34, 4'h0, 1'b0, 1'b1, 8'h00,               1'b0, 1'b0, 1'b0, 1'b1,             1'b0);
        tbl[11] = mk(8'hFF, 8'h00, 4'h2, 1'b1, 1'b0, 8'h00,               1'b1, 1'b0, 1'b0, 1'b1,             1'b0);
        tbl[12] = mk(8'h11, 8'h22, 4'h8, 1'b0, 1'b0, 8'h33,               1'b1, 1'b0, 1'b0, 1'b0,             1'b0);
        tbl[13] = mk(8'h01, 8'h01, 4'hC, 1'b0, 1'b0, 8'h00,               1'b0, 1'b0, 1'b0, 1'b1,             1'b0);
        tbl[14] = mk(8'hFF, 8'h01, 4'h8, 1'b1, 1'b0, 8'h34,               1'b1, 1'b0, 1'b0, 1'b0,             1'b0);
        tbl[15] = mk(8'h01, 8'h01, 4'h8, 1'b0, 1'b1, 8'h02,               1'b1, 1'b0, 1'b0, 1'b0,             1'b0);
        tbl[16] = mk(8'hFF, 8'hFF, 4'h1, 1'b1, 1'b0, 8'h02,               1'b1, 1'b0, 1'b0, 1'b0,             1'b0);

        bus.A = '0;
        bus.B = '0;
        bus.opcode = 4'h0;
        bus.out_ready = 1'b1;
        idle();

        fork
            // result monitor: compare each result as the consumer takes it
            forever begin
                @(negedge clk);
                if (rst_n && bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: got r=%h with empty queue want no result", bus.result);
                    end else begin
                        out_t e;
                        e = exp_q.pop_front();
                        txn++;
                        $display("txn %0d got r=%h st=%b c=%b v=%b z=%b n=%b want %h",
                                 txn, bus.result, bus.status, bus.carry, bus.ovf,
                                 bus.zero, bus.neg, e);
                        check("txn", 32'({bus.result, bus.status, bus.carry, bus.ovf, bus.zero, bus.neg}), 32'(e));
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: got no finish want finish before 200000");
                $fatal(1, "watchdog");
            end
        join_none

        // reset state
        #2;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", 32'({bus.status, bus.carry, bus.ovf, bus.zero, bus.neg}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        check("idle_result", 32'(bus.result), 32'd0);

        // directed table, back-to-back with out_ready high
        for (int i = 0; i < 17; i++) send(tbl[i]);
        idle();
        drain_check("table_drain");
        check("hold_after_drain", 32'(bus.result), 32'(tbl[16].r));

        // random vectors against the integer model
        for (int i = 0; i < 12; i++) begin
            logic [3:0] op;
            op = ops[$urandom_range(0, 5)];
            v = model(8'($urandom), 8'($urandom), op, 1'($urandom), 1'($urandom_range(0, 3) == 0));
            send(v);
        end
        idle();
        drain_check("random_drain");

        // backpressure: one accept, then 3 stalled cycles with a pending offer
        bus.out_ready = 1'b0;
        send(mk(8'h11, 8'h22, 4'h8, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        bus.A = 8'h01; bus.B = 8'h02; bus.opcode = 4'h8;
        bus.acc_sel = 1'b0; bus.acc_clr = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_result", 32'({bus.result, bus.status, bus.zero}), 32'({8'h33, 1'b1, 1'b0}));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(model(8'h01, 8'h02, 4'h8, 1'b0, 1'b0));
        send(model(8'h00, 8'h01, 4'h4, 1'b1, 1'b0));
        send(model(8'h00, 8'h05, 4'h8, 1'b1, 1'b0));
        idle();
        drain_check("bp_drain");

        // reset while a result is held under backpressure
        bus.out_ready = 1'b0;
        send(mk(8'h01, 8'h01, 4'h8, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        idle();
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_result", 32'(bus.result), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        m_acc = 8'h00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        // accumulator was cleared by reset: 0 + 5
        send(mk(8'hAA, 8'h05, 4'h8, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        idle();
        drain_check("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Registered, parametrised successor to the team's one-hot-opcode combinational ALU. It accepts operand/opcode transactions over a valid/ready handshake and computes add, subtract, OR or AND with an optional accumulator operand. It presents a registered result with status and arithmetic flags one cycle later, and holds that result under output backpressure. It sits between the button-decoded opcode source and the display/consumer logic.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  transaction offered on A, B, opcode, acc_sel.
- in_ready  output  1  block can accept a transaction this cycle.
- A  input  WIDTH  operand A, unsigned/two's-complement.
- B  input  WIDTH  operand B.
- opcode  input  4  one-hot: 1000 add (UP), 0100 sub (DOWN), 0010 OR (RIGHT), 0001 AND (LEFT).
- acc_sel  input  1  when 1, accumulator replaces A as the first operand.
- acc_clr  input  1  synchronous accumulator clear, independent of handshake.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  registered result.
- status  output  1  1 = opcode was a legal one-hot code.
- carry  output  1  add: carry-out; sub: borrow (opA < B unsigned); logic ops: 0.
- ovf  output  1  signed overflow for add/sub; 0 for logic ops.
- zero  output  1  result == 0.
- neg  output  1  result[WIDTH-1].

## Operation
- Accept = in_valid && in_ready. in_ready = !out_valid || out_ready, a combinational function of registered state and out_ready only.
- Effective accumulator: acc_eff = acc_clr ? 0 : acc.
- opA = acc_sel ? acc_eff : A.
- Add and subtract are computed at WIDTH+1 bits. Result = low WIDTH bits; bit WIDTH drives carry/borrow.
- ovf for add: opA and B have the same sign and the result sign differs. ovf for sub: opA and B have different signs and the result sign differs from opA.
- Illegal opcode (zero bits or more than one bit set): result = 0, status = 0, carry = ovf = neg = 0, zero = 1. The transaction still completes and asserts out_valid.
- Accumulator next state:
  - accepted legal op: the new result;
  - otherwise, if acc_clr: 0;
  - otherwise: hold.
- Illegal ops never write the accumulator, but acc_clr still applies in that cycle.
- On accept, result, status and all flags load together and out_valid goes to 1.
- out_valid && out_ready && !in_valid: out_valid drops to 0. result and flags hold their last values.

## Timing
- Reset values: out_valid 0, result 0, status 0, carry 0, ovf 0, zero 0, neg 0, accumulator 0. in_ready = 1 while in reset.
- Latency: accept in cycle N gives the result visible with out_valid = 1 after edge N+1.
- Throughput: 1 transaction/cycle when out_ready is held high. Accept and drain in the same cycle keeps out_valid = 1 with the new result.
- Backpressure: while out_valid && !out_ready, in_ready = 0 and result/flags/status stay bit-stable.
- acc_sel in back-to-back cycles sees the accumulator value written by the previous accepted op (no bubble).
- Reset asserted mid-transaction discards the pending result immediately. No transaction completes after rst_n rises until a new accept.

## Configuration
- ALU_PIPE_SAT_EN defined: unsigned saturation.
  - Add with carry = 1 gives result all-ones.
  - Sub with borrow = 1 gives result 0.
  - carry/ovf still report the raw condition; zero/neg reflect the saturated result.
  - The accumulator stores the saturated value.
- Undefined: add and sub wrap modulo 2^WIDTH.

## Test plan
- Reset then idle: out_valid = 0, result = 0, in_ready = 1; rst_n low mid-backpressure clears out_valid.
- WIDTH = 8, A = 0xF0, B = 0x20, opcode 1000, out_ready = 1 -> next cycle result = 0x10, carry = 1, status = 1. With ALU_PIPE_SAT_EN: result = 0xFF.
- A = 0x7F, B = 0x01 add -> result = 0x80, ovf = 1, neg = 1. A = 0x05, B = 0x05 sub -> result = 0x00, zero = 1, carry = 0.
- opcode 0110, A = 0xAA, B = 0x55 -> result = 0, status = 0, zero = 1; accumulator unchanged.
- Accumulator chain: add 0x03+0x04, then acc_sel add B = 0x10 -> 0x17; acc_clr with acc_sel AND B = 0xFF in the same cycle -> result = 0x00.
- Hold out_ready = 0 for 3 cycles after one accept -> in_ready = 0 and result stable. Then out_ready = 1 with in_valid = 1 -> back-to-back accepts, one result per cycle.
